// File: rtl/core_pkg.sv
// Shared decode constants: opcodes, control-bundle layout and decode FSM encoding.
package core_pkg;

   localparam int CTRL_W = 12;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // out_ctrl bit positions, MSB first
   localparam int CTRL_REG_WRITE  = 11;
   localparam int CTRL_MEM_WRITE  = 10;
   localparam int CTRL_MEM_READ   = 9;
   localparam int CTRL_MEM_TO_REG = 8;
   localparam int CTRL_JUMP       = 7;
   localparam int CTRL_BRANCH     = 6;
   localparam int CTRL_JALR       = 5;
   localparam int CTRL_U_SRC      = 4;
   localparam int CTRL_UJ_SRC     = 3;
   localparam int CTRL_ALU_SRC    = 2;
   localparam int CTRL_MULDIV     = 1;
   localparam int CTRL_ILLEGAL    = 0;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   // funct3[2] separates DIV*/REM* from MUL*
   function automatic logic [7:0] muldiv_cycles(input logic is_div,
                                                input logic [7:0] mul_n,
                                                input logic [7:0] div_n);
      if (is_div) begin
         return div_n;
      end else begin
         return mul_n;
      end
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I(+M) opcode decoder producing the packed control bundle.
module ctrl_decode
   import core_pkg::*;
#(
   parameter int EN_M = 1
) (
   input  logic [31:0]       instr,
   output logic [CTRL_W-1:0] ctrl
);

   logic unused_s;
   assign unused_s = ^instr[24:7];

   // opcode (and funct7 for M-extension) to control bits
   always_comb begin
      ctrl = '0;
      case (instr[6:0])
         OPC_OP: begin
            if (instr[31:25] != FUNCT7_MULDIV) begin
               ctrl[CTRL_REG_WRITE] = 1'b1;
               ctrl[CTRL_UJ_SRC]    = 1'b1;
            end else if (EN_M != 32'sd0) begin
               ctrl[CTRL_REG_WRITE] = 1'b1;
               ctrl[CTRL_UJ_SRC]    = 1'b1;
               ctrl[CTRL_MULDIV]    = 1'b1;
            end else begin
               ctrl[CTRL_ILLEGAL]   = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            ctrl[CTRL_REG_WRITE] = 1'b1;
            ctrl[CTRL_UJ_SRC]    = 1'b1;
            ctrl[CTRL_ALU_SRC]   = 1'b1;
         end
         OPC_LOAD: begin
            ctrl[CTRL_REG_WRITE]  = 1'b1;
            ctrl[CTRL_MEM_READ]   = 1'b1;
            ctrl[CTRL_MEM_TO_REG] = 1'b1;
            ctrl[CTRL_UJ_SRC]     = 1'b1;
            ctrl[CTRL_ALU_SRC]    = 1'b1;
         end
         OPC_JALR: begin
            ctrl[CTRL_REG_WRITE] = 1'b1;
            ctrl[CTRL_JALR]      = 1'b1;
            ctrl[CTRL_UJ_SRC]    = 1'b1;
            ctrl[CTRL_ALU_SRC]   = 1'b1;
         end
         OPC_STORE: begin
            ctrl[CTRL_MEM_WRITE] = 1'b1;
            ctrl[CTRL_UJ_SRC]    = 1'b1;
            ctrl[CTRL_ALU_SRC]   = 1'b1;
         end
         OPC_BRANCH: begin
            ctrl[CTRL_BRANCH] = 1'b1;
            ctrl[CTRL_UJ_SRC] = 1'b1;
         end
         OPC_LUI: begin
            ctrl[CTRL_REG_WRITE] = 1'b1;
         end
         OPC_AUIPC: begin
            ctrl[CTRL_REG_WRITE] = 1'b1;
            ctrl[CTRL_U_SRC]     = 1'b1;
         end
         OPC_JAL: begin
            ctrl[CTRL_REG_WRITE] = 1'b1;
            ctrl[CTRL_JUMP]      = 1'b1;
            ctrl[CTRL_BRANCH]    = 1'b1;
            ctrl[CTRL_UJ_SRC]    = 1'b1;
         end
         default: begin
            ctrl[CTRL_ILLEGAL] = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/decode_ctrl.sv
// Decode stage: one-entry skid holding a decoded instruction, stalling for multi-cycle mul/div.
module decode_ctrl
   import core_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int EN_M       = 1,
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 33
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [XLEN-1:0]   in_pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [XLEN-1:0]   out_pc,
   output logic [CTRL_W-1:0] out_ctrl
);

   localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES);
   localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES);

   state_e            state_r, state_s;
   logic [7:0]        cnt_r, cnt_s;
   logic [CTRL_W-1:0] ctrl_s;
   logic              in_ready_s;
   logic              accept_s;
   logic              out_valid_r;
   logic [31:0]       out_instr_r;
   logic [XLEN-1:0]   out_pc_r;
   logic [CTRL_W-1:0] out_ctrl_r;

   ctrl_decode #(.EN_M(EN_M)) u_ctrl_decode (
      .instr (in_instr),
      .ctrl  (ctrl_s)
   );

   // upstream ready: free slot, or slot draining this cycle
   always_comb begin
      if (rst || flush) begin
         in_ready_s = 1'b0;
      end else if (state_r == ST_EMPTY) begin
         in_ready_s = 1'b1;
      end else if (state_r == ST_FULL) begin
         in_ready_s = out_ready;
      end else begin
         in_ready_s = 1'b0;
      end
   end

   assign accept_s = in_valid && in_ready_s;

   // next state and mul/div hold counter
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      if (flush) begin
         state_s = ST_EMPTY;
         cnt_s   = 8'd0;
      end else if (accept_s) begin
         if (ctrl_s[CTRL_MULDIV]) begin
            state_s = ST_BUSY;
            cnt_s   = muldiv_cycles(in_instr[14], MUL_LOAD, DIV_LOAD);
         end else begin
            state_s = ST_FULL;
            cnt_s   = 8'd0;
         end
      end else begin
         case (state_r)
            ST_EMPTY: begin
               state_s = ST_EMPTY;
            end
            ST_BUSY: begin
               if (cnt_r <= 8'd1) begin
                  state_s = ST_FULL;
                  cnt_s   = 8'd0;
               end else begin
                  cnt_s   = cnt_r - 8'd1;
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  state_s = ST_EMPTY;
               end else begin
                  state_s = ST_FULL;
               end
            end
            default: begin
               state_s = ST_EMPTY;
               cnt_s   = 8'd0;
            end
         endcase
      end
   end

   // state, counter and registered output bundle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_EMPTY;
         cnt_r       <= 8'd0;
         out_valid_r <= 1'b0;
         out_instr_r <= NOP_INSTR;
         out_pc_r    <= '0;
         out_ctrl_r  <= '0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         out_valid_r <= (state_s == ST_FULL);
         if (accept_s) begin
            out_instr_r <= in_instr;
            out_pc_r    <= in_pc;
            out_ctrl_r  <= ctrl_s;
         end else begin
            out_instr_r <= out_instr_r;
            out_pc_r    <= out_pc_r;
            out_ctrl_r  <= out_ctrl_r;
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_instr = out_instr_r;
   assign out_pc    = out_pc_r;
   assign out_ctrl  = out_ctrl_r;

endmodule

// File: tb/tb_decode_ctrl.sv
// Scoreboard bench for decode_ctrl: driver pushes expected bundles with due cycles, monitor pops on handshake.
module tb_decode_ctrl;

   localparam int MUL_N = 2;
   localparam int DIV_N = 33;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [11:0] ctrl;
      int          due;
   } item_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = 32'd0;
   logic [31:0] in_pc = 32'd0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [11:0] out_ctrl;

   logic        m_valid = 1'b0;
   logic        m_in_ready;
   logic [31:0] m_instr = 32'd0;
   logic        m_out_valid;
   logic [31:0] m_out_instr;
   logic [31:0] m_out_pc;
   logic [11:0] m_out_ctrl;

   item_t exp_q[$];
   int    cyc = 0;
   int    n_checks = 0;
   int    n_fail = 0;
   bit    mon_en = 1'b0;

   decode_ctrl #(.XLEN(32), .EN_M(1), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_ctrl(out_ctrl)
   );

   decode_ctrl #(.XLEN(32), .EN_M(0), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut_nom (
      .clk(clk), .rst(rst), .in_valid(m_valid), .in_ready(m_in_ready),
      .in_instr(m_instr), .in_pc(32'h0000_0400), .flush(1'b0),
      .out_valid(m_out_valid), .out_ready(1'b1), .out_instr(m_out_instr),
      .out_pc(m_out_pc), .out_ctrl(m_out_ctrl)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected control bundle, bit layout reg_write..illegal written out as hex
   function automatic logic [11:0] exp_ctrl(input logic [31:0] ins, input bit en_m);
      case (ins[6:0])
         7'b0110011: begin
            if (ins[31:25] == 7'b0000001) return en_m ? 12'h80A : 12'h001;
            else return 12'h808;
         end
         7'b0010011: return 12'h80C;
         7'b0000011: return 12'hB0C;
         7'b1100111: return 12'h82C;
         7'b0100011: return 12'h40C;
         7'b1100011: return 12'h048;
         7'b0110111: return 12'h800;
         7'b0010111: return 12'h810;
         7'b1101111: return 12'h8C8;
         default:    return 12'h001;
      endcase
   endfunction

   function automatic int extra_cycles(input logic [31:0] ins);
      logic [11:0] c;
      c = exp_ctrl(ins, 1'b1);
      if (c == 12'h80A) return ins[14] ? DIV_N : MUL_N;
      return 0;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // One bench cycle: drive after the edge, check in_ready, record any accept.
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic ordy, input logic fl, input logic r);
      bit    exp_rdy;
      item_t it;
      @(posedge clk);
      #1;
      in_valid  = v;
      in_instr  = ins;
      in_pc     = p;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
      #2;
      exp_rdy = !r && !fl && (exp_q.size() == 0 || (cyc >= exp_q[0].due && ordy));
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (v && exp_rdy) begin
         it.instr = ins;
         it.pc    = p;
         it.ctrl  = exp_ctrl(ins, 1'b1);
         it.due   = cyc + 1 + extra_cycles(ins);
         exp_q.push_back(it);
      end
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, ordy, 1'b0, 1'b0);
   endtask

   // Monitor: front of queue must be presented exactly from its due cycle on
   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
            check("out_valid", {31'd0, out_valid}, 32'd1);
            check("out_instr", out_instr, exp_q[0].instr);
            check("out_pc", out_pc, exp_q[0].pc);
            check("out_ctrl", {20'd0, out_ctrl}, {20'd0, exp_q[0].ctrl});
            if (out_ready) void'(exp_q.pop_front());
         end else begin
            check("out_valid_idle", {31'd0, out_valid}, 32'd0);
         end
         if (flush || rst) exp_q.delete();
      end
   end

   function automatic logic [31:0] rand_instr();
      logic [6:0]  opcs[9];
      logic [31:0] ins;
      int          k;
      opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
               7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
      ins = $urandom;
      k = $urandom_range(0, 10);
      if (k < 9) ins[6:0] = opcs[k];
      if (ins[6:0] == 7'b0110011 && $urandom_range(0, 1) == 1) ins[31:25] = 7'b0000001;
      return ins;
   endfunction

   initial begin
      // reset and reset-state checks
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      mon_en = 1'b1;
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'h0000_0013);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_ctrl", {20'd0, out_ctrl}, 32'd0);

      // add, then lw/jalr back-to-back
      step(1'b1, 32'h003100B3, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
      idle(2, 1'b1);
      step(1'b1, 32'h0000A083, 32'h0000_0104, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h00008067, 32'h0000_0108, 1'b1, 1'b0, 1'b0);
      idle(2, 1'b1);

      // mul latency, upstream stalled while busy
      step(1'b1, 32'h023100B3, 32'h0000_010C, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 32'h003100B3, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
      idle(2, 1'b1);

      // div flushed in the 10th busy cycle, new instruction offered alongside flush
      step(1'b1, 32'h023140B3, 32'h0000_0110, 1'b1, 1'b0, 1'b0);
      idle(9, 1'b1);
      step(1'b1, 32'h003100B3, 32'h0000_0114, 1'b1, 1'b1, 1'b0);
      idle(2, 1'b1);

      // all-ones is illegal
      step(1'b1, 32'hFFFFFFFF, 32'h0000_0118, 1'b1, 1'b0, 1'b0);
      idle(2, 1'b1);

      // downstream stall for several cycles with upstream pressing
      step(1'b1, 32'h00208093, 32'h0000_011C, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, 32'h0000A083, 32'h0000_0300, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b1);

      // reset while holding an output
      step(1'b1, 32'h00112023, 32'h0000_0120, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b1);

      // reset while a divide is pending
      step(1'b1, 32'h023150B3, 32'h0000_0124, 1'b1, 1'b0, 1'b0);
      idle(5, 1'b1);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
      idle(40, 1'b1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 9) < 6, rand_instr(), $urandom,
              $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3,
              $urandom_range(0, 199) < 2);
      end

      // drain, bounded
      for (int i = 0; i < 60 && exp_q.size() > 0; i++) idle(1, 1'b1);
      check("drained", exp_q.size(), 32'd0);

      // EN_M=0 instance: mul is illegal and single-cycle
      @(posedge clk);
      #1;
      m_valid = 1'b1;
      m_instr = 32'h023100B3;
      #2;
      check("nom_in_ready", {31'd0, m_in_ready}, 32'd1);
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      #2;
      check("nom_out_valid", {31'd0, m_out_valid}, 32'd1);
      check("nom_out_ctrl", {20'd0, m_out_ctrl}, {20'd0, exp_ctrl(32'h023100B3, 1'b0)});
      check("nom_out_instr", m_out_instr, 32'h023100B3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
